// File: rtl/del_mod.sv
// del_mod: triangle-LFO delay-amount generator (base .. base+depth); define DEL_MOD_SLEW_EN to slew-limit del
module del_mod #(
    parameter int BUFR_DEPTH  = 512,
    parameter int PHASE_WIDTH = 16,
    localparam int DEL_WIDTH  = $clog2(BUFR_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   vld_i,
    input  logic [PHASE_WIDTH-1:0] rate,
    input  logic [DEL_WIDTH-1:0]   base,
    input  logic [DEL_WIDTH-1:0]   depth,
    output logic [DEL_WIDTH-1:0]   del,
    output logic                   del_vld,
    output logic                   dir
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RISE = 2'd1;
    localparam logic [1:0] FALL = 2'd2;
    localparam logic [PHASE_WIDTH:0] PMAX = {1'b0, {PHASE_WIDTH{1'b1}}};
    localparam logic [DEL_WIDTH:0] DMAX = (DEL_WIDTH+1)'(BUFR_DEPTH - 1);

    logic [1:0]                     state_q, state_d;
    logic [PHASE_WIDTH-1:0]         acc_q, acc_d;
    logic [PHASE_WIDTH:0]           sum;
    logic                           dir_q;
    logic                           v1_q, v2_q, v3_q;
    logic                           en1_q, en2_q;
    logic [PHASE_WIDTH-1:0]         acc1_q;
    logic [DEL_WIDTH-1:0]           base1_q, depth1_q, base2_q, off2_q;
    logic [PHASE_WIDTH+DEL_WIDTH-1:0] prod;
    logic [DEL_WIDTH:0]             sum3;
    logic [DEL_WIDTH-1:0]           target, step, del_q, del_d;

    assign sum = {1'b0, acc_q} + {1'b0, rate};

    // LFO next state: en drop forces IDLE at once, everything else advances only on a strobe
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        if (!en) begin
            state_d = IDLE;
            acc_d   = '0;
        end else if (vld_i) begin
            if (state_q == IDLE) begin
                state_d = RISE;
                acc_d   = rate;
            end else if (state_q == RISE && rate != '0) begin
                state_d = (sum >= PMAX) ? FALL : RISE;
                acc_d   = (sum >= PMAX) ? '1 : sum[PHASE_WIDTH-1:0];
            end else if (state_q == FALL && rate != '0) begin
                state_d = (acc_q <= rate) ? RISE : FALL;
                acc_d   = (acc_q <= rate) ? '0 : acc_q - rate;
            end else if (state_q != RISE && state_q != FALL) begin
                state_d = IDLE;
                acc_d   = '0;
            end
        end
    end

    // LFO state, accumulator and direction flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dir_q   <= (state_d == RISE);
        end
    end

    // Pipeline valids; reset drops any sample in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= vld_i;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    assign prod = acc1_q * depth1_q;

    // Pipeline data: stage 1 captures the updated phase and per-sample controls, stage 2 scales
    always_ff @(posedge clk) begin
        acc1_q   <= acc_d;
        base1_q  <= base;
        depth1_q <= depth;
        en1_q    <= en;
        off2_q   <= DEL_WIDTH'(prod >> PHASE_WIDTH);
        base2_q  <= base1_q;
        en2_q    <= en1_q;
    end

    assign sum3   = {1'b0, base2_q} + {1'b0, off2_q};
    assign target = (sum3 > DMAX) ? DMAX[DEL_WIDTH-1:0] : sum3[DEL_WIDTH-1:0];

`ifdef DEL_MOD_SLEW_EN
    assign step = (target > del_q) ? del_q + 1'b1 : (target < del_q) ? del_q - 1'b1 : del_q;
`else
    assign step = target;
`endif

    assign del_d = v2_q ? (en2_q ? step : target) : del_q;

    // Output delay register, only moves when a sample leaves stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            del_q <= '0;
        end else begin
            del_q <= del_d;
        end
    end

    assign del     = del_q;
    assign del_vld = v3_q;
    assign dir     = dir_q;
endmodule

// File: tb/tb_del_mod.sv
// tb_del_mod: directed self-checking bench for del_mod
module tb_del_mod;
    logic        clk = 1'b0;
    logic        rst, en, vld_i;
    logic [15:0] rate;
    logic [8:0]  base, depth, del;
    logic        del_vld, dir;
    logic [8:0]  exp_del;
    int          tests = 0;
    int          failed = 0;
    int          tri_t [9] = '{64, 128, 192, 255, 191, 127, 63, 0, 64};
    logic        tri_d [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};

    del_mod dut (
        .clk(clk), .rst(rst), .en(en), .vld_i(vld_i), .rate(rate),
        .base(base), .depth(depth), .del(del), .del_vld(del_vld), .dir(dir)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] nd(input logic [8:0] p, input logic [8:0] t, input logic e);
`ifdef DEL_MOD_SLEW_EN
        if (!e) return t;
        return (t > p) ? p + 9'd1 : (t < p) ? p - 9'd1 : p;
`else
        return t;
`endif
    endfunction

    task automatic strobe(output logic dir_s, output logic stray, output logic hit, output logic [8:0] del_s);
        vld_i = 1'b1;
        @(posedge clk); #1;
        vld_i = 1'b0;
        dir_s = dir;
        stray = del_vld;
        @(posedge clk); #1;
        stray |= del_vld;
        @(posedge clk); #1;
        hit   = del_vld;
        del_s = del;
        @(posedge clk); #1;
        stray |= del_vld;
    endtask

    task automatic go_idle();
        en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic d, s, h;
        logic [8:0] v;
        rst = 1'b1; en = 1'b0; vld_i = 1'b1; rate = '0; base = '0; depth = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            vld_i = ~vld_i;
            tests++;
            if (del_vld !== 1'b0 || del !== 9'd0 || dir !== 1'b0) begin
                failed++;
                $display("FAIL reset cyc%0d: vld=%b del=%0d dir=%b want 0/0/0", i, del_vld, del, dir);
            end
        end
        rst = 1'b0; vld_i = 1'b0; exp_del = '0;
        base = 9'd100;
        strobe(d, s, h, v);
        exp_del = nd(exp_del, 9'd100, 1'b0);
        tests++;
        if ({s, h} !== 2'b01 || v !== exp_del) begin
            failed++;
            $display("FAIL reset_first: stray=%b hit=%b del=%0d want 0 1 %0d", s, h, v, exp_del);
        end
    endtask

    task automatic test_static();
        logic d, s, h;
        logic [8:0] v;
        en = 1'b1; rate = '0; base = 9'd100; depth = 9'd50;
        for (int i = 0; i < 4; i++) begin
            strobe(d, s, h, v);
            exp_del = nd(exp_del, 9'd100, 1'b1);
            tests++;
            if ({s, h} !== 2'b01 || v !== exp_del || d !== 1'b1) begin
                failed++;
                $display("FAIL static%0d: stray=%b hit=%b del=%0d dir=%b want 0 1 %0d 1", i, s, h, v, d, exp_del);
            end
        end
    endtask

    task automatic test_triangle();
        logic d, s, h;
        logic [8:0] v;
        go_idle();
        en = 1'b1; rate = 16'd16384; base = '0; depth = 9'd256;
        for (int i = 0; i < 9; i++) begin
            strobe(d, s, h, v);
            exp_del = nd(exp_del, 9'(tri_t[i]), 1'b1);
            tests++;
            if ({s, h} !== 2'b01 || v !== exp_del || d !== tri_d[i]) begin
                failed++;
                $display("FAIL triangle%0d: stray=%b hit=%b del=%0d dir=%b want 0 1 %0d %b", i, s, h, v, d, exp_del, tri_d[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic d, s, h;
        logic [8:0] v;
        logic [8:0] t [3] = '{511, 511, 500};
        logic       dd [3] = '{1, 0, 1};
        go_idle();
        en = 1'b1; rate = 16'd65535; base = 9'd500; depth = 9'd100;
        for (int i = 0; i < 3; i++) begin
            strobe(d, s, h, v);
            exp_del = nd(exp_del, t[i], 1'b1);
            tests++;
            if ({s, h} !== 2'b01 || v !== exp_del || d !== dd[i]) begin
                failed++;
                $display("FAIL saturation%0d: stray=%b hit=%b del=%0d dir=%b want 0 1 %0d %b", i, s, h, v, d, exp_del, dd[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        go_idle();
        en = 1'b1; rate = 16'd16384; base = '0; depth = 9'd256;
        vld_i = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk); #1;
            if (k == 7) vld_i = 1'b0;
            tests++;
            if (del_vld !== (k >= 2 && k <= 9)) begin
                failed++;
                $display("FAIL b2b_vld%0d: got %b want %b", k, del_vld, (k >= 2 && k <= 9));
            end
            if (k >= 2 && k <= 9) begin
                exp_del = nd(exp_del, 9'(tri_t[k-2]), 1'b1);
                n++;
                tests++;
                if (del !== exp_del) begin
                    failed++;
                    $display("FAIL b2b_del%0d: got %0d want %0d", k - 2, del, exp_del);
                end
            end
        end
        tests++;
        if (n != 8) begin
            failed++;
            $display("FAIL b2b_count: got %0d want 8", n);
        end
    endtask

    task automatic test_en_drop();
        logic d, s, h;
        logic [8:0] v;
        go_idle();
        en = 1'b1; rate = 16'd16384; base = '0; depth = 9'd256;
        for (int i = 0; i < 5; i++) begin
            strobe(d, s, h, v);
            exp_del = nd(exp_del, 9'(tri_t[i]), 1'b1);
            tests++;
            if (v !== exp_del || d !== tri_d[i]) begin
                failed++;
                $display("FAIL endrop_ramp%0d: del=%0d dir=%b want %0d %b", i, v, d, exp_del, tri_d[i]);
            end
        end
        en = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (dir !== 1'b0) begin
            failed++;
            $display("FAIL endrop_dir: got %b want 0", dir);
        end
        base = 9'd37;
        strobe(d, s, h, v);
        exp_del = 9'd37;
        tests++;
        if ({s, h} !== 2'b01 || v !== exp_del || d !== 1'b0) begin
            failed++;
            $display("FAIL endrop_base: stray=%b hit=%b del=%0d dir=%b want 0 1 37 0", s, h, v, d);
        end
        en = 1'b1; base = '0;
        strobe(d, s, h, v);
        exp_del = nd(exp_del, 9'd64, 1'b1);
        tests++;
        if (v !== exp_del || d !== 1'b1) begin
            failed++;
            $display("FAIL endrop_restart: del=%0d dir=%b want %0d 1", v, d, exp_del);
        end
    endtask

    task automatic test_mid_reset();
        logic d, s, h;
        logic [8:0] v;
        en = 1'b0; base = 9'd100;
        strobe(d, s, h, v);
        tests++;
        if (v !== 9'd100) begin
            failed++;
            $display("FAIL midrst_pre: del=%0d want 100", v);
        end
        base = 9'd200;
        vld_i = 1'b1;
        @(posedge clk); #1;
        vld_i = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (del_vld !== 1'b0 || del !== 9'd0) begin
                failed++;
                $display("FAIL midrst%0d: vld=%b del=%0d want 0 0", i, del_vld, del);
            end
            @(posedge clk); #1;
        end
        exp_del = '0;
    endtask

    initial begin
        test_reset();
        test_static();
        test_triangle();
        test_saturation();
        test_back_to_back();
        test_en_drop();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
